// File: rtl/vadd_pkg.sv
// Shared constants and types for the vector add result stage.
package vadd_pkg;

  localparam logic [1:0] SEW8  = 2'd0;
  localparam logic [1:0] SEW16 = 2'd1;
  localparam logic [1:0] SEW32 = 2'd2;
  localparam logic [1:0] SEW64 = 2'd3;

  localparam int OP_SUB   = 1;
  localparam int OP_REV   = 0;
  localparam int OP_WIDEN = 4;

  localparam int LANE_W  = 10;
  localparam int DATA_W  = 64;
  localparam int RES_W   = 81;
  localparam int SEW_W   = 2;
  localparam int OPSEL_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [7:0]        cmask;
    logic              vxsat;
  } beat_t;

  localparam beat_t BEAT_ZERO = '{data: 64'd0, cmask: 8'd0, vxsat: 1'b0};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Without 64-bit support the widest SEW code folds onto 32-bit elements.
  function automatic logic [1:0] eff_sew(input logic [1:0] sew, input logic en64);
    logic [1:0] r;
    if ((sew == SEW64) && !en64) begin
      r = SEW32;
    end else begin
      r = sew;
    end
    return r;
  endfunction

endpackage

// File: rtl/vadd_result_stage_if.sv
// Upstream adder beat and downstream writeback handshake of the result stage.
interface vadd_result_stage_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [vadd_pkg::RES_W-1:0]    in_result;
  logic [vadd_pkg::DATA_W-1:0]   in_vec0;
  logic [vadd_pkg::DATA_W-1:0]   in_vec1;
  logic [vadd_pkg::SEW_W-1:0]    in_sew;
  logic [vadd_pkg::OPSEL_W-1:0]  in_opSel;
  logic                          in_sat;
  logic                          in_signed;
  logic                          out_valid;
  logic                          out_ready;
  logic [vadd_pkg::DATA_W-1:0]   out_data;
  logic [7:0]                    out_cmask;
  logic                          out_vxsat;

  modport slave (
    input  in_valid, in_result, in_vec0, in_vec1, in_sew, in_opSel, in_sat, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_cmask, out_vxsat
  );

  modport master (
    output in_valid, in_result, in_vec0, in_vec1, in_sew, in_opSel, in_sat, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_cmask, out_vxsat
  );

endinterface

// File: rtl/vadd_elem_sat.sv
// One element of the result stage: carry/borrow mask bit plus optional
// unsigned or signed saturation of the raw adder sum.
module vadd_elem_sat #(
  parameter int EW = 8
) (
  input  logic [EW-1:0] raw_i,
  input  logic          carry_i,
  input  logic          a_msb_i,
  input  logic          b_msb_i,
  input  logic          is_sub_i,
  input  logic          sat_i,
  input  logic          signed_i,
  output logic [EW-1:0] value_o,
  output logic          cmask_o,
  output logic          sat_o
);

  logic cm_s;
  logic ovf_s;

  // A subtract's carry-out is the inverted borrow; cm_s also flags unsigned overflow.
  assign cm_s    = is_sub_i ? ~carry_i : carry_i;
  assign ovf_s   = (is_sub_i ? (a_msb_i != b_msb_i) : (a_msb_i == b_msb_i)) &&
                   (raw_i[EW-1] != a_msb_i);
  assign cmask_o = cm_s;

  // Saturated element value and saturation event
  always_comb begin
    value_o = raw_i;
    sat_o   = 1'b0;
    if (sat_i && signed_i) begin
      if (ovf_s) begin
        value_o = a_msb_i ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
        sat_o   = 1'b1;
      end else begin
        value_o = raw_i;
      end
    end else if (sat_i) begin
      if (cm_s) begin
        value_o = is_sub_i ? {EW{1'b0}} : {EW{1'b1}};
        sat_o   = 1'b1;
      end else begin
        value_o = raw_i;
      end
    end else begin
      value_o = raw_i;
    end
  end

endmodule

// File: rtl/vadd_result_stage.sv
// Registered result stage of the vector adder: guard stripping, carry masks,
// saturation, and a two-entry skid buffer giving a registered in_ready.
module vadd_result_stage
  import vadd_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 5,
  parameter int ENABLE_64_BIT  = 0
) (
  input logic                 clk,
  input logic                 rst,
  vadd_result_stage_if.slave  bus
);

  logic [SEW_WIDTH-1:0]      sew_eff_s;
  logic [OPSEL_WIDTH-1:0]    op_s;
  logic                      is_sub_s;
  logic                      is_rev_s;
  logic [REQ_DATA_WIDTH-1:0] raw_s;
  logic [REQ_DATA_WIDTH-1:0] op_a_s;
  logic [REQ_DATA_WIDTH-1:0] op_b_s;
  logic [63:0]               lane_data_s  [4];
  logic [7:0]                lane_cmask_s [4];
  logic [7:0]                lane_sat_s   [4];
  beat_t                     new_s;
  beat_t                     main_q, main_d, skid_q, skid_d;
  skid_state_e               state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      accept_s, drain_s;
  logic                      unused_s;

  assign sew_eff_s = eff_sew(bus.in_sew, ENABLE_64_BIT != 0);
  assign op_s      = bus.in_opSel;
  assign is_sub_s  = op_s[OP_SUB];
  assign is_rev_s  = op_s[OP_SUB] & op_s[OP_REV];
  // Effective operand order decides which sign bit is the minuend's.
  assign op_a_s    = is_rev_s ? bus.in_vec1 : bus.in_vec0;
  assign op_b_s    = is_rev_s ? bus.in_vec0 : bus.in_vec1;
  assign unused_s  = ^{bus.in_result, op_s, bus.in_vec0, bus.in_vec1};

  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign raw_s[8*i +: 8] = bus.in_result[LANE_W*i + 1 +: 8];
  end

  for (genvar g = 0; g < 4; g++) begin : g_sew
    localparam int EW = 8 << g;
    localparam int NE = 8 >> g;
    logic [63:0]   data_s;
    logic [NE-1:0] cm_s;
    logic [NE-1:0] sat_s;
    for (genvar k = 0; k < NE; k++) begin : g_elem
      localparam int J = (k + 1) * (1 << g) - 1;
      vadd_elem_sat #(.EW(EW)) u_elem (
        .raw_i    (raw_s[k*EW +: EW]),
        .carry_i  (bus.in_result[LANE_W*J + LANE_W]),
        .a_msb_i  (op_a_s[k*EW + EW - 1]),
        .b_msb_i  (op_b_s[k*EW + EW - 1]),
        .is_sub_i (is_sub_s),
        .sat_i    (bus.in_sat),
        .signed_i (bus.in_signed),
        .value_o  (data_s[k*EW +: EW]),
        .cmask_o  (cm_s[k]),
        .sat_o    (sat_s[k])
      );
    end
    if (NE < 8) begin : g_pad
      assign lane_cmask_s[g] = {{(8-NE){1'b0}}, cm_s};
      assign lane_sat_s[g]   = {{(8-NE){1'b0}}, sat_s};
    end else begin : g_full
      assign lane_cmask_s[g] = cm_s;
      assign lane_sat_s[g]   = sat_s;
    end
    assign lane_data_s[g] = data_s;
  end

  assign new_s.data  = lane_data_s[sew_eff_s];
  assign new_s.cmask = lane_cmask_s[sew_eff_s];
  assign new_s.vxsat = |lane_sat_s[sew_eff_s];

  assign accept_s = bus.in_valid && in_ready_q;
  assign drain_s  = out_valid_q && bus.out_ready;

  // Skid buffer next-state: main feeds the output, skid absorbs one stalled beat
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_ONE;
          main_d  = new_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          state_d = ST_ONE;
          main_d  = new_s;
        end else if (accept_s) begin
          state_d = ST_TWO;
          skid_d  = new_s;
        end else if (drain_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BEAT_ZERO;
      skid_q      <= BEAT_ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q.data;
  assign bus.out_cmask = main_q.cmask;
  assign bus.out_vxsat = main_q.vxsat;

endmodule

// File: doc/vadd_result_stage.md
# vadd_result_stage

Registered output stage for the vector add unit. It consumes the 81-bit guard-interleaved sum from the combinational adder and strips the guard bits to produce a packed 64-bit element result. It also produces per-element carry/borrow masks (vmadc/vmsbc) and applies optional unsigned/signed saturation with a vxsat flag. It sits between the adder and the ALU writeback mux, with a valid/ready handshake and a skid buffer so `in_ready` is a registered signal.

## Interface
- `REQ_DATA_WIDTH`, 64: element-data width; only 64 is supported.
- `SEW_WIDTH`, 2: width of the SEW code.
- `OPSEL_WIDTH`, 5: width of the adder op select.
- `ENABLE_64_BIT`, 0: when 0, SEW code 3 is treated as 32-bit.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_result`  in  81  packed adder sum; byte i data at [10i+8:10i+1], guards at 10i and 10i+9, top carry at bit 80.
- `in_vec0`, `in_vec1`  in  64 each  original, uninverted operands; used only for signed-overflow sign bits.
- `in_sew`  in  2  element width: 0=8, 1=16, 2=32, 3=64 bits.
- `in_opSel`  in  5  adder op select; [1:0] 0x/10/11 = add / vec0−vec1 / vec1−vec0; [4] must be 0 (widening is out of scope).
- `in_sat`  in  1  saturate the result.
- `in_signed`  in  1  signed saturation (when `in_sat`=1).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  64  element results.
- `out_cmask`  out  8  carry-out (add) or borrow-out (sub) per element, LSB-aligned; upper bits zero.
- `out_vxsat`  out  1  at least one element saturated in this beat.

## Operation
- **Data extraction.** `raw[8i+7:8i] = in_result[10i+8:10i+1]`.
- **Element count.** n = 8 >> sew_eff, where sew_eff = (sew==3 && !ENABLE_64_BIT) ? 2 : sew. Element k spans bytes k·2^sew_eff … (k+1)·2^sew_eff − 1. Top byte index j = (k+1)·2^sew_eff − 1.
- **Carry-out.** c_k = `in_result[10j+10]`.
  - Add: `out_cmask[k]` = c_k.
  - Subtract (either order): `out_cmask[k]` = ~c_k (borrow).
  - `out_cmask[7:n]` = 0.
- **Unsigned saturation** (`in_sat`=1, `in_signed`=0):
  - Add with c_k=1: element becomes all-ones.
  - Subtract with borrow: element becomes 0.
- **Signed saturation** (`in_sat`=1, `in_signed`=1):
  - Let a, b be the element MSBs of the effective minuend/addend pair after op order: add (vec0, vec1); sub (vec0, vec1); rsub (vec1, vec0). Let s be the MSB of raw.
  - Overflow on add: a==b && s!=a. Overflow on sub: a!=b && s!=a.
  - On overflow the element becomes 0x7F…F if a=0, else 0x80…0.
- `out_vxsat` = OR of saturation events over elements 0..n−1; it is 0 when `in_sat`=0.
- Every combinational result is computed in the accept cycle and registered.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears on `out_*` after edge t.
- Transfer occurs on valid&&ready on either side; no combinational path from `out_ready` to `in_ready`.
- Two registers, main and skid:
  - `in_ready` = ~skid_valid, registered.
  - If main is full, `out_ready`=0 and a beat is accepted, the beat goes to skid.
  - When main drains, skid moves to main on the same edge.
  - Simultaneous accept and drain with skid empty: main is overwritten; no bubble.
- States: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept with no drain.
  - ONE→EMPTY on drain with no accept.
  - ONE→ONE on accept with drain, or when idle.
  - TWO→ONE on drain; in TWO `in_ready`=0.
- Reset (`rst`=0 at an edge): state EMPTY; `out_valid`=0, `in_ready`=1 from the following cycle; `out_data`=0, `out_cmask`=0, `out_vxsat`=0.
- Reset mid-operation discards both buffered beats.
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `vadd_pkg`:
  - SEW code constants (SEW8=0, SEW16=1, SEW32=2, SEW64=3).
  - opSel field positions (OP_SUB=1, OP_REV=0, OP_WIDEN=4).
  - Guard-lane stride constant LANE_W=10.
- One sub-module, `vadd_elem_sat`, handles one element: inputs are raw bytes, carry, and sign bits; outputs are the saturated value, cmask bit, and sat flag. It is instantiated per SEW through a generate and muxed by sew_eff.
- The skid buffer is inline in the top module.

## Test plan
1. sew=0, add, byte lanes 0xFF+0x01 in lane 0 and 0x10+0x20 elsewhere, no sat -> `out_data` byte0=0x00, others 0x30; `out_cmask`=0x01; `out_vxsat`=0; `out_valid` one cycle after accept.
2. sew=1, unsigned-sat add 0xFFF0+0x0020 in element 0 -> element 0x FFFF; `out_cmask`[0]=1; `out_cmask`[7:4]=0; `out_vxsat`=1.
3. sew=2, signed-sat sub 0x80000000−0x00000001 -> 0x80000000, `out_vxsat`=1; rsub with the same operands -> 0x00000001−0x80000000 = 0x7FFFFFFF, `out_vxsat`=1.
4. sew=3 with ENABLE_64_BIT=0 -> treated as sew=2: two elements; `out_cmask`[7:2]=0.
5. Backpressure: `out_ready`=0 for 3 cycles while 3 beats are offered -> 2 accepted, `in_ready` drops after the second; release `out_ready` -> beats emerge in order with no loss or duplication; back-to-back throughput is 1 beat/cycle when `out_ready`=1.
6. `rst`=0 asserted while in TWO -> next cycle `out_valid`=0, `in_ready`=1, all outputs 0; no stale beat appears after reset is released.
